intt_level_sched: RTL and testbench

Sequencer for one inverse-NTT transform over N = 2^LOGN coefficients. Walks every INTT level and, per level, every (chunk, gap) butterfly pair, issuing one butterfly per cycle. Each issue carries coefficient addresses x/y, twiddle index, a skip flag and a valid code. It sits between the coefficient/twiddle memory address ports and a single `ibutt` lane. It inserts a pipeline-drain barrier between levels so that level l+1 never reads coefficients that level l has not yet written back.

---
 rtl/FHE_ALU_PKG.sv | 13 +
 rtl/intt_addr_gen.sv | 46 ++++
 rtl/intt_level_sched.sv | 253 +++++++++++++++++++++++++
 tb/tb_intt_level_sched.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/FHE_ALU_PKG.sv
// Shared INTT datapath parameters and the level-sequencer state encoding.
package FHE_ALU_PKG;
  localparam int logN           = 3;
  localparam int IBUTTER_CYCLES = 4;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    SCALE,
    DONE
  } intt_sched_state_t;
endpackage

// File: rtl/intt_addr_gen.sv
// Registered butterfly address generator: maps level/chunk/gap counters to
// coefficient addresses x, y and twiddle index, updating only on i_adv.
module intt_addr_gen #(
  parameter int LOGN = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_clr,
  input  logic            i_adv,
  input  logic [LOGN-1:0] i_level,
  input  logic [LOGN-2:0] i_chunk,
  input  logic [LOGN-2:0] i_gap,
  output logic [LOGN-1:0] o_x,
  output logic [LOGN-1:0] o_y,
  output logic [LOGN-1:0] o_root
);
  localparam int unsigned N = 1 << LOGN;

  logic [LOGN-1:0] w_span;
  logic [LOGN-1:0] w_x;
  logic [LOGN-1:0] w_root;
  logic [LOGN-1:0] r_x;
  logic [LOGN-1:0] r_y;
  logic [LOGN-1:0] r_root;

  // chunk*2*gap_size is a shift by level+1; level+1 never exceeds LOGN.
  assign w_span = LOGN'(1) << i_level;
  assign w_x    = (LOGN'(i_chunk) << (i_level + 1'b1)) + LOGN'(i_gap);
  assign w_root = LOGN'(N >> (i_level + 1'b1)) + LOGN'(i_chunk);

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_x    <= '0;
      r_y    <= '0;
      r_root <= '0;
    end else if (i_adv) begin
      r_x    <= w_x;
      r_y    <= w_x + w_span;
      r_root <= w_root;
    end
  end

  assign o_x    = r_x;
  assign o_y    = r_y;
  assign o_root = r_root;
endmodule

// File: rtl/intt_level_sched.sv
// Inverse-NTT level sequencer with inter-level drain barrier.
// Optional N^-1 scaling pass enabled by defining INTT_SCHED_SCALE_EN.
module intt_level_sched
  import FHE_ALU_PKG::*;
#(
  parameter int LOGN         = logN,
  parameter int DRAIN_CYCLES = IBUTTER_CYCLES
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [LOGN-1:0] skip_mask,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [1:0]      in_valid_code,
  output logic            skip_level,
  output logic [LOGN-1:0] x,
  output logic [LOGN-1:0] y,
  output logic [LOGN-1:0] root_idx,
  output logic [LOGN-1:0] level,
  output logic [LOGN-2:0] chunk_idx,
  output logic [LOGN-2:0] gap_idx,
  output logic [LOGN-1:0] num_chunk,
  output logic [LOGN-1:0] gap_size,
  output logic            busy,
  output logic            done
);
  // state | meaning
  // IDLE  | waiting for start, all outputs zero
  // ISSUE | one butterfly offered per cycle for the current level
  // DRAIN | barrier so the next pass never reads unwritten coefficients
  // SCALE | N^-1 scaling pass over adjacent pairs (optional)
  // DONE  | single-cycle completion pulse
  localparam int unsigned   N        = 1 << LOGN;
  localparam int            DW       = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [LOGN-1:0] HALF     = LOGN'(N >> 1);
  localparam logic [LOGN-1:0] LAST_LVL = LOGN'(LOGN - 1);

  intt_sched_state_t r_state, w_nxt_state;

  logic [LOGN-1:0] r_level, w_nxt_level;
  logic [LOGN-2:0] r_chunk, w_nxt_chunk;
  logic [LOGN-2:0] r_gap, w_nxt_gap;
  logic [LOGN-1:0] r_gap_size, w_nxt_gap_size;
  logic [LOGN-1:0] r_num_chunk, w_nxt_num_chunk;
  logic [LOGN-1:0] r_mask, w_nxt_mask;
  logic [DW-1:0]   r_drain, w_nxt_drain;
  logic            r_out_valid, w_nxt_valid;
  logic [1:0]      r_code, w_nxt_code;
  logic            r_skip, w_nxt_skip;
  logic            r_busy, w_nxt_busy;
  logic            r_done, w_nxt_done;
  logic            w_adv, w_clr, w_fire, w_last;
  logic [LOGN-1:0] w_nl;
  logic [LOGN-1:0] w_root;
`ifdef INTT_SCHED_SCALE_EN
  logic            r_scale, w_nxt_scale;
`endif

  assign w_fire = r_out_valid && out_ready;
  assign w_last = (LOGN'(r_chunk) == r_num_chunk - 1'b1) &&
                  (LOGN'(r_gap) == r_gap_size - 1'b1);
  assign w_nl   = r_level + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nxt_state;
  end

  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_level     = r_level;
    w_nxt_chunk     = r_chunk;
    w_nxt_gap       = r_gap;
    w_nxt_gap_size  = r_gap_size;
    w_nxt_num_chunk = r_num_chunk;
    w_nxt_mask      = r_mask;
    w_nxt_drain     = r_drain;
    w_nxt_valid     = r_out_valid;
    w_nxt_code      = r_code;
    w_nxt_skip      = r_skip;
    w_nxt_busy      = r_busy;
    w_nxt_done      = 1'b0;
    w_adv           = 1'b0;
    w_clr           = 1'b0;
`ifdef INTT_SCHED_SCALE_EN
    w_nxt_scale     = r_scale;
`endif
    case (r_state)
      IDLE: begin
        if (start) begin
          w_nxt_state     = ISSUE;
          w_nxt_level     = '0;
          w_nxt_chunk     = '0;
          w_nxt_gap       = '0;
          w_nxt_gap_size  = LOGN'(1);
          w_nxt_num_chunk = HALF;
          w_nxt_mask      = skip_mask;
          w_nxt_valid     = 1'b1;
          w_nxt_code      = 2'd1;
          w_nxt_skip      = skip_mask[0];
          w_nxt_busy      = 1'b1;
          w_adv           = 1'b1;
        end
      end
`ifdef INTT_SCHED_SCALE_EN
      ISSUE, SCALE: begin
`else
      ISSUE: begin
`endif
        if (w_fire) begin
          if (w_last) begin
            w_nxt_state = DRAIN;
            w_nxt_valid = 1'b0;
            w_nxt_code  = 2'd0;
            w_nxt_drain = r_skip ? '0 : DW'(DRAIN_CYCLES - 1);
          end else begin
            w_adv = 1'b1;
            if (LOGN'(r_gap) == r_gap_size - 1'b1) begin
              w_nxt_gap   = '0;
              w_nxt_chunk = r_chunk + 1'b1;
            end else begin
              w_nxt_gap = r_gap + 1'b1;
            end
          end
        end
      end
      DRAIN: begin
        if (r_drain != '0) begin
          w_nxt_drain = r_drain - 1'b1;
`ifdef INTT_SCHED_SCALE_EN
        end else if (r_scale) begin
          w_nxt_state = DONE;
          w_nxt_done  = 1'b1;
        end else if (r_level == LAST_LVL) begin
          // Scaling reuses the level-0 pairing (x=2k, y=2k+1); root is forced to slot 0.
          w_nxt_state     = SCALE;
          w_nxt_scale     = 1'b1;
          w_nxt_level     = '0;
          w_nxt_chunk     = '0;
          w_nxt_gap       = '0;
          w_nxt_gap_size  = LOGN'(1);
          w_nxt_num_chunk = HALF;
          w_nxt_valid     = 1'b1;
          w_nxt_code      = 2'd2;
          w_nxt_skip      = 1'b0;
          w_adv           = 1'b1;
`else
        end else if (r_level == LAST_LVL) begin
          w_nxt_state = DONE;
          w_nxt_done  = 1'b1;
`endif
        end else begin
          w_nxt_state     = ISSUE;
          w_nxt_level     = w_nl;
          w_nxt_chunk     = '0;
          w_nxt_gap       = '0;
          w_nxt_gap_size  = LOGN'(1) << w_nl;
          w_nxt_num_chunk = LOGN'(N >> (w_nl + 1'b1));
          w_nxt_valid     = 1'b1;
          w_nxt_code      = 2'd1;
          w_nxt_skip      = r_mask[w_nl];
          w_adv           = 1'b1;
        end
      end
      DONE: begin
        w_nxt_state     = IDLE;
        w_nxt_level     = '0;
        w_nxt_chunk     = '0;
        w_nxt_gap       = '0;
        w_nxt_gap_size  = '0;
        w_nxt_num_chunk = '0;
        w_nxt_mask      = '0;
        w_nxt_drain     = '0;
        w_nxt_valid     = 1'b0;
        w_nxt_code      = 2'd0;
        w_nxt_skip      = 1'b0;
        w_nxt_busy      = 1'b0;
        w_clr           = 1'b1;
`ifdef INTT_SCHED_SCALE_EN
        w_nxt_scale     = 1'b0;
`endif
      end
      default: w_nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_level     <= '0;
      r_chunk     <= '0;
      r_gap       <= '0;
      r_gap_size  <= '0;
      r_num_chunk <= '0;
      r_mask      <= '0;
      r_drain     <= '0;
      r_out_valid <= 1'b0;
      r_code      <= 2'd0;
      r_skip      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef INTT_SCHED_SCALE_EN
      r_scale     <= 1'b0;
`endif
    end else begin
      r_level     <= w_nxt_level;
      r_chunk     <= w_nxt_chunk;
      r_gap       <= w_nxt_gap;
      r_gap_size  <= w_nxt_gap_size;
      r_num_chunk <= w_nxt_num_chunk;
      r_mask      <= w_nxt_mask;
      r_drain     <= w_nxt_drain;
      r_out_valid <= w_nxt_valid;
      r_code      <= w_nxt_code;
      r_skip      <= w_nxt_skip;
      r_busy      <= w_nxt_busy;
      r_done      <= w_nxt_done;
`ifdef INTT_SCHED_SCALE_EN
      r_scale     <= w_nxt_scale;
`endif
    end
  end

  intt_addr_gen #(.LOGN(LOGN)) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_clr),
    .i_adv   (w_adv),
    .i_level (w_nxt_level),
    .i_chunk (w_nxt_chunk),
    .i_gap   (w_nxt_gap),
    .o_x     (x),
    .o_y     (y),
    .o_root  (w_root)
  );

`ifdef INTT_SCHED_SCALE_EN
  assign root_idx = r_scale ? '0 : w_root;
`else
  assign root_idx = w_root;
`endif

  assign out_valid     = r_out_valid;
  assign in_valid_code = r_code;
  assign skip_level    = r_skip;
  assign level         = r_level;
  assign chunk_idx     = r_chunk;
  assign gap_idx       = r_gap;
  assign num_chunk     = r_num_chunk;
  assign gap_size      = r_gap_size;
  assign busy          = r_busy;
  assign done          = r_done;
endmodule

// File: tb/tb_intt_level_sched.sv
// Directed scoreboard bench for intt_level_sched at LOGN=3, DRAIN_CYCLES=4.
module tb_intt_level_sched;
  localparam int LOGN = 3;
  localparam int D    = 4;
  localparam int N    = 1 << LOGN;

  logic            clk = 1'b0;
  logic            rst, start, out_ready;
  logic [LOGN-1:0] skip_mask;
  logic            out_valid, skip_level, busy, done;
  logic [1:0]      in_valid_code;
  logic [LOGN-1:0] x, y, root_idx, level, num_chunk, gap_size;
  logic [LOGN-2:0] chunk_idx, gap_idx;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [LOGN-1:0] x, y, root;
    logic [1:0]      code;
    logic            skip;
    logic [LOGN-1:0] lvl, gs, nc;
    logic [LOGN-2:0] ch, gp;
    int              cyc;
  } exp_t;

  exp_t q[$];

  intt_level_sched #(.LOGN(LOGN), .DRAIN_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .start(start), .skip_mask(skip_mask),
    .out_ready(out_ready), .out_valid(out_valid), .in_valid_code(in_valid_code),
    .skip_level(skip_level), .x(x), .y(y), .root_idx(root_idx), .level(level),
    .chunk_idx(chunk_idx), .gap_idx(gap_idx), .num_chunk(num_chunk),
    .gap_size(gap_size), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected issue stream and completion cycle, cycle 1 = first cycle after start.
  task automatic build(input logic [LOGN-1:0] mask, output int done_cyc);
    int   t;
    exp_t e;
    t = 1;
    q.delete();
    for (int l = 0; l < LOGN; l++) begin
      int gs = 1 << l;
      int nc = N / (2 * gs);
      for (int c = 0; c < nc; c++) begin
        for (int g = 0; g < gs; g++) begin
          e.x = LOGN'(c * 2 * gs + g);
          e.y = LOGN'(c * 2 * gs + g + gs);
          e.root = LOGN'(nc + c);
          e.code = 2'd1;
          e.skip = mask[l];
          e.lvl = LOGN'(l);
          e.gs = LOGN'(gs);
          e.nc = LOGN'(nc);
          e.ch = (LOGN-1)'(c);
          e.gp = (LOGN-1)'(g);
          e.cyc = t;
          t++;
          q.push_back(e);
        end
      end
      t += mask[l] ? 1 : D;
    end
`ifdef INTT_SCHED_SCALE_EN
    for (int k = 0; k < N / 2; k++) begin
      e.x = LOGN'(2 * k);
      e.y = LOGN'(2 * k + 1);
      e.root = '0;
      e.code = 2'd2;
      e.skip = 1'b0;
      e.lvl = '0;
      e.gs = '0;
      e.nc = '0;
      e.ch = '0;
      e.gp = '0;
      e.cyc = t;
      t++;
      q.push_back(e);
    end
    t += D;
`endif
    done_cyc = t;
  endtask

  task automatic run(input logic [LOGN-1:0] mask, input int stall_lo, input int stall_hi,
                     input int pulse_cyc, input int rst_cyc);
    int   done_cyc, last;
    bit   chk_cyc;
    exp_t h;
    build(mask, done_cyc);
    chk_cyc = (stall_lo < 0);
    if (!chk_cyc) done_cyc += stall_hi - stall_lo + 1;
    skip_mask = mask;
    last = (rst_cyc >= 0) ? rst_cyc : done_cyc + 2;
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      start     = (c == 0) || (c == pulse_cyc);
      out_ready = !(c >= stall_lo && c <= stall_hi);
      rst       = (c == rst_cyc);
      chk("busy", busy, (c >= 1 && c <= done_cyc));
      chk("done", done, (c == done_cyc));
      if (chk_cyc) chk("valid_cycle", out_valid, (q.size() > 0 && q[0].cyc == c));
      if (out_valid && q.size() > 0) begin
        h = q[0];
        chk("issue", {x, y, root_idx, in_valid_code, skip_level},
            {h.x, h.y, h.root, h.code, h.skip});
        if (h.code == 2'd1)
          chk("loop", {level, gap_size, num_chunk, chunk_idx, gap_idx},
              {h.lvl, h.gs, h.nc, h.ch, h.gp});
        if (out_ready) void'(q.pop_front());
      end else if (out_valid) begin
        chk("extra_issue", out_valid, 1'b0);
      end
      if (!out_valid) chk("code_idle", in_valid_code, 2'd0);
    end
    if (rst_cyc < 0) chk("all_issued", q.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b1;
    skip_mask = '0;
    repeat (2) @(negedge clk);
    chk("reset_zero", {out_valid, in_valid_code, skip_level, x, y, root_idx, level,
                       chunk_idx, gap_idx, num_chunk, gap_size, busy, done}, 0);
    rst = 1'b0;
    @(negedge clk);

    run('0, -1, -1, -1, -1);
    run('0, 2, 3, -1, -1);
    run(3'b010, -1, -1, -1, -1);
    run('0, -1, -1, 5, -1);
    run('0, -1, -1, -1, 10);
    @(negedge clk);
    chk("mid_reset_zero", {out_valid, in_valid_code, skip_level, x, y, root_idx, level,
                           chunk_idx, gap_idx, num_chunk, gap_size, busy, done}, 0);
    rst = 1'b0;
    q.delete();
    run('0, -1, -1, -1, -1);
    run(3'b111, -1, -1, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
